// File: rtl/iob_pwm_capture.sv
// PWM capture: measures period and high time of pwm_i in clk cycles
// and hands each completed measurement out on a valid/ready port.
module iob_pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             pwm_i,
  input  logic [CNT_W-1:0] timeout_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic             r_s1;
  logic             r_s2;
  logic             r_p;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_ovr;
  logic             r_to;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_hcnt;
  logic             w_pub;
  logic             w_to;
  logic             w_rise;
  logic             w_fall;
  logic             w_lim;
  logic             w_ovset;
  logic             w_load;

  assign w_rise = r_s2 & ~r_p;
  assign w_fall = ~r_s2 & r_p;
  assign w_lim  = ((timeout_i != '0) && (r_cnt == timeout_i))
                || (r_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // In HIGH the limit wins over a fall: a saturated high time can
  // never belong to a measurable period. In LOW a rise still counts.
  always_comb begin
    w_nxt  = r_state;
    w_cnt  = r_cnt;
    w_hcnt = r_hcnt;
    w_pub  = 1'b0;
    w_to   = 1'b0;
    if (!en_i) begin
      w_nxt = S_IDLE;
      w_cnt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: w_nxt = S_ARM;
        S_ARM: begin
          if (w_rise) begin
            w_nxt = S_HIGH;
            w_cnt = CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (w_lim) begin
            w_to  = 1'b1;
            w_nxt = S_ARM;
            w_cnt = '0;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
            if (w_fall) begin
              w_hcnt = r_cnt;
              w_nxt  = S_LOW;
            end
          end
        end
        S_LOW: begin
          if (w_rise) begin
            w_pub = 1'b1;
            w_cnt = CNT_W'(1);
            w_nxt = S_HIGH;
          end else if (w_lim) begin
            w_to  = 1'b1;
            w_nxt = S_ARM;
            w_cnt = '0;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign w_load  = w_pub & (~r_valid | ready_i);
  assign w_ovset = w_pub & r_valid & ~ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_p     <= 1'b0;
      r_cnt   <= '0;
      r_hcnt  <= '0;
      r_per   <= '0;
      r_high  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_s1   <= pwm_i;
      r_s2   <= r_s1;
      r_p    <= r_s2;
      r_cnt  <= w_cnt;
      r_hcnt <= w_hcnt;
      if (w_load) begin
        r_per   <= r_cnt;
        r_high  <= r_hcnt;
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
      r_ovr <= w_ovset | (r_ovr & ~clr_i);
      r_to  <= w_to | (r_to & ~clr_i);
    end
  end

  assign period_o  = r_per;
  assign high_o    = r_high;
  assign valid_o   = r_valid;
  assign overrun_o = r_ovr;
  assign timeout_o = r_to;

endmodule

// File: tb/tb_iob_pwm_capture.sv
// Bench for iob_pwm_capture: timestamp-based reference model compared
// every cycle, directed scenarios with literal pins, then random traffic.
module tb_iob_pwm_capture;
  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en_i;
  logic         clr_i;
  logic         pwm_i;
  logic         ready_i;
  logic [W-1:0] timeout_i;
  logic [W-1:0] period_o;
  logic [W-1:0] high_o;
  logic         valid_o;
  logic         overrun_o;
  logic         timeout_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iob_pwm_capture #(.CNT_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en_i),
    .clr_i    (clr_i),
    .pwm_i    (pwm_i),
    .timeout_i(timeout_i),
    .period_o (period_o),
    .high_o   (high_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .overrun_o(overrun_o),
    .timeout_o(timeout_o)
  );

  // Reference model: pin samples delayed by the synchroniser, then
  // measurement expressed as timestamps of the observed edges.
  bit       hist[3];
  int       now = 0;
  int       mode = 0;
  int       t_rise = 0;
  bit       have_fall = 0;
  int       hi_len = 0;
  bit [W-1:0] m_per = '0;
  bit [W-1:0] m_high = '0;
  bit       m_v = 0;
  bit       m_ov = 0;
  bit       m_to = 0;
  bit       rise_s;
  bit       fall_s;
  bit       lim;
  bit       pub;
  bit       tos;
  int       el;
  int       p_len;

  always @(posedge clk) begin
    now = now + 1;
    if (rst) begin
      mode = 0;
      m_per = '0;
      m_high = '0;
      m_v = 0;
      m_ov = 0;
      m_to = 0;
      hist[0] = 0;
      hist[1] = 0;
      hist[2] = 0;
    end else begin
      rise_s = hist[1] && !hist[2];
      fall_s = !hist[1] && hist[2];
      pub = 0;
      tos = 0;
      p_len = 0;
      el = now - t_rise;
      lim = ((timeout_i != 0) && (el == int'(timeout_i))) || (el == MAX);
      if (!en_i) begin
        mode = 0;
      end else if (mode == 0) begin
        mode = 1;
      end else if (mode == 1) begin
        if (rise_s) begin
          mode = 2;
          t_rise = now;
          have_fall = 0;
        end
      end else if (!have_fall) begin
        if (lim) begin
          tos = 1;
          mode = 1;
        end else if (fall_s) begin
          have_fall = 1;
          hi_len = el;
        end
      end else begin
        if (rise_s) begin
          pub = 1;
          p_len = el;
          t_rise = now;
          have_fall = 0;
        end else if (lim) begin
          tos = 1;
          mode = 1;
        end
      end
      if (pub && m_v && !ready_i) begin
        m_ov = 1;
      end else if (clr_i) begin
        m_ov = 0;
      end
      if (pub && (!m_v || ready_i)) begin
        m_per = W'(p_len);
        m_high = W'(hi_len);
        m_v = 1;
      end else if (m_v && ready_i) begin
        m_v = 0;
      end
      if (tos) m_to = 1;
      else if (clr_i) m_to = 0;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = pwm_i;
    end
  end

  always @(negedge clk) begin
    checks = checks + 1;
    if ({valid_o, overrun_o, timeout_o, period_o, high_o} !==
        {m_v, m_ov, m_to, m_per, m_high}) begin
      errors = errors + 1;
      $display("FAIL model t=%0t: dut v=%b ov=%b to=%b per=%0d hi=%0d, expected v=%b ov=%b to=%b per=%0d hi=%0d",
               $time, valid_o, overrun_o, timeout_o, period_o, high_o,
               m_v, m_ov, m_to, m_per, m_high);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < per; i++) begin
        pwm_i = (i < hi);
        @(negedge clk);
      end
    end
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en_i = 1'b0;
    clr_i = 1'b0;
    pwm_i = 1'b0;
    ready_i = 1'b1;
    timeout_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_period", int'(period_o), 0);
    chk("reset_flags", int'({overrun_o, timeout_o}), 0);
    rst = 1'b0;
    en_i = 1'b1;

    run(100, 30, 5);
    chk("steady_period", int'(period_o), 100);
    chk("steady_high", int'(high_o), 30);

    ready_i = 1'b0;
    run(100, 30, 3);
    chk("held_valid", int'(valid_o), 1);
    chk("overrun_set", int'(overrun_o), 1);
    ready_i = 1'b1;
    run(100, 30, 2);
    chk("after_ovr_period", int'(period_o), 100);
    chk("after_ovr_high", int'(high_o), 30);
    pulse_clr();
    chk("overrun_clr", int'(overrun_o), 0);

    timeout_i = W'(50);
    pwm_i = 1'b1;
    repeat (80) @(negedge clk);
    chk("stuck_timeout", int'(timeout_o), 1);
    chk("stuck_novalid", int'(valid_o), 0);
    pulse_clr();
    chk("timeout_clr", int'(timeout_o), 0);

    timeout_i = '0;
    run(300, 150, 3);
    chk("sat_timeout", int'(timeout_o), 1);
    chk("sat_novalid", int'(valid_o), 0);
    pulse_clr();

    run(2, 1, 20);
    chk("fast_period", int'(period_o), 2);
    chk("fast_high", int'(high_o), 1);
    chk("fast_no_ovr", int'(overrun_o), 0);

    for (int i = 0; i < 100; i++) begin
      pwm_i = (i < 30);
      en_i = !(i == 10 || i == 11);
      @(negedge clk);
    end
    en_i = 1'b1;
    run(100, 30, 3);
    chk("en_period", int'(period_o), 100);
    chk("en_high", int'(high_o), 30);

    for (int i = 0; i < 100; i++) begin
      pwm_i = (i < 30);
      rst = (i == 60 || i == 61);
      @(negedge clk);
      if (i == 61) begin
        chk("rst_mid_out", int'({valid_o, overrun_o, timeout_o}), 0);
        chk("rst_mid_per", int'(period_o), 0);
      end
    end
    rst = 1'b0;

    for (int k = 0; k < 60; k++) begin
      int per;
      int hi;
      per = int'($urandom_range(2, 120));
      hi = int'($urandom_range(1, per - 1));
      if ($urandom_range(0, 2) == 0) timeout_i = W'($urandom_range(1, 255));
      else timeout_i = '0;
      for (int i = 0; i < per; i++) begin
        pwm_i = (i < hi);
        ready_i = ($urandom_range(0, 3) != 0);
        clr_i = ($urandom_range(0, 31) == 0);
        en_i = ($urandom_range(0, 299) != 0);
        @(negedge clk);
      end
    end
    en_i = 1'b1;
    clr_i = 1'b0;
    ready_i = 1'b1;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
